// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned StateW            = 2;
  localparam int unsigned MemTimeoutDefault = 255;
  localparam int unsigned WaitW             = 16;

  // Encoding 3 is never entered and decodes as StError.
  typedef enum logic [StateW-1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of ID.
module load_use_detect (
  input  logic       mem_read_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_r1_i,
  input  logic       use_r2_i,
  output logic       lu_o
);

  logic hit_r1;
  logic hit_r2;

  assign hit_r1 = use_r1_i && (rd_i == rs1_i);
  assign hit_r2 = use_r2_i && (rd_i == rs2_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_o   = mem_read_i && (rd_i != 5'd0) && (hit_r1 || hit_r2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, data-memory waits.
// Build option PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegisterRd_i,
  input  logic [4:0]       IFID_RegisterR1_i,
  input  logic [4:0]       IFID_RegisterR2_i,
  input  logic             IFID_UseR1_i,
  input  logic             IFID_UseR2_i,
  input  logic             Branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             pipe_hold_o,
  output logic             MEMWB_Bubble_o,
  output logic             timeout_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             lu;
  logic             mem_stall;
  logic             in_error;

  load_use_detect u_load_use_detect (
    .mem_read_i (IDEX_MemRead_i),
    .rd_i       (IDEX_RegisterRd_i),
    .rs1_i      (IFID_RegisterR1_i),
    .rs2_i      (IFID_RegisterR2_i),
    .use_r1_i   (IFID_UseR1_i),
    .use_r2_i   (IFID_UseR2_i),
    .lu_o       (lu)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_stall = 1'b0;
    in_error  = 1'b0;
    case (state_q)
      StRun: begin
        if (mem_req_i && !mem_ack_i) begin
          mem_stall = 1'b1;
          state_d   = StMemWait;
          wait_d    = WaitW'(1);
        end
      end
      StMemWait: begin
        // An ack completes the access this cycle, so the cycle behaves as RUN.
        if (mem_ack_i) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_q == TimeoutVal) begin
            state_d = StError;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end
      default: begin
        mem_stall = 1'b1;
        in_error  = 1'b1;
        state_d   = StError;
      end
    endcase
  end

  always_comb begin
    PCWrite_o      = 1'b1;
    IFID_Write_o   = 1'b1;
    IFID_Flush_o   = 1'b0;
    IDEX_Bubble_o  = 1'b0;
    pipe_hold_o    = 1'b0;
    MEMWB_Bubble_o = 1'b0;
    timeout_o      = in_error;
    if (mem_stall) begin
      PCWrite_o      = 1'b0;
      IFID_Write_o   = 1'b0;
      pipe_hold_o    = 1'b1;
      MEMWB_Bubble_o = 1'b1;
    end else if (lu) begin
      // Load-use beats a taken branch; the branch is re-presented next cycle.
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_Flush_o = 1'b1;
    end
    if (rst_i) begin
      PCWrite_o      = 1'b0;
      IFID_Write_o   = 1'b0;
      IFID_Flush_o   = 1'b1;
      IDEX_Bubble_o  = 1'b1;
      pipe_hold_o    = 1'b0;
      MEMWB_Bubble_o = 1'b1;
      timeout_o      = 1'b0;
    end
  end

  assign state_o = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (IFID_Flush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
